// File: rtl/memory_pkg.sv
// Shared memory-subsystem types: MMU write packet, load/store unit state and request bundle.
package memory_pkg;

    localparam int LANES  = 8;
    localparam int ADDR_W = 18;
    localparam int DATA_W = 9;

    typedef struct packed {
        logic              en;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              forcewrite;
    } write_req_pkt;

    typedef enum logic [2:0] {
        IDLE,
        STORE,
        LOAD_WAIT,
        LOAD_ISSUE,
        LOAD_CAPTURE,
        RESP
    } lsu_state_t;

    typedef struct packed {
        logic                         is_store;
        logic                         forcewrite;
        logic [LANES-1:0]             mask;
        logic [ADDR_W-1:0]            base_addr;
        logic [LANES-1:0][ADDR_W-1:0] addr;
        logic [LANES-1:0][DATA_W-1:0] data;
    } lsu_req_t;

    // Consecutive load addresses; wraps modulo 2^ADDR_W.
    function automatic logic [LANES-1:0][ADDR_W-1:0] lane_addrs(input logic [ADDR_W-1:0] base);
        for (int i = 0; i < LANES; i++) begin
            lane_addrs[i] = base + ADDR_W'(i);
        end
    endfunction

endpackage

// File: rtl/load_store_unit.sv
// Per-warp load/store sequencer feeding the banked MMU: lane-masked store packets,
// drain-gated consecutive loads, registered load response.
module load_store_unit
    import memory_pkg::*;
#(
    parameter int DRAIN_CYCLES = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    // valid/ready: a request transfers on a cycle with req_valid && req_ready;
    // req_ready depends on state only, never on req_valid.
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_is_store,
    input  logic                         req_forcewrite,
    input  logic [LANES-1:0]             req_mask,
    input  logic [ADDR_W-1:0]            req_base_addr,
    input  logic [LANES-1:0][ADDR_W-1:0] req_addr,
    input  logic [LANES-1:0][DATA_W-1:0] req_data,
    output write_req_pkt [LANES-1:0]     mmu_write_reqs,
    input  logic                         mmu_stall,
    input  logic [LANES-1:0][DATA_W-1:0] mmu_read_data,
    output logic                         resp_valid,
    output logic [LANES-1:0][DATA_W-1:0] resp_data,
    output logic                         busy,
    output logic [2:0]                   o_dbg_state,
    output logic [$clog2(DRAIN_CYCLES+1)-1:0] o_dbg_drain_cnt
);

    localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);

    lsu_state_t                   r_state;
    lsu_state_t                   w_next_state;
    logic [CNT_W-1:0]             r_drain_cnt;
    write_req_pkt [LANES-1:0]     r_pkts;
    write_req_pkt [LANES-1:0]     w_pkts_next;
    logic [ADDR_W-1:0]            r_base;
    logic [ADDR_W-1:0]            w_base;
    logic [LANES-1:0][ADDR_W-1:0] w_load_addrs;
    logic                         r_resp_valid;
    logic [LANES-1:0][DATA_W-1:0] r_resp_data;
    lsu_req_t                     w_req;
    logic                         w_accept;
    logic                         w_load_ok;

    assign w_req = '{is_store:   req_is_store,
                     forcewrite: req_forcewrite,
                     mask:       req_mask,
                     base_addr:  req_base_addr,
                     addr:       req_addr,
                     data:       req_data};

    assign req_ready    = (r_state == IDLE);
    assign w_accept     = req_valid && req_ready;
    // Queued MMU writes must have drained, and the MMU must be able to take the read now.
    assign w_load_ok    = (r_drain_cnt == '0) && !mmu_stall;
    assign w_base       = (r_state == IDLE) ? w_req.base_addr : r_base;
    assign w_load_addrs = lane_addrs(w_base);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_req.is_store) begin
                        w_next_state = (w_req.mask != '0) ? STORE : IDLE;
                    end else begin
                        w_next_state = w_load_ok ? LOAD_ISSUE : LOAD_WAIT;
                    end
                end
            end
            STORE:        if (!mmu_stall) w_next_state = IDLE;
            LOAD_WAIT:    if (w_load_ok) w_next_state = LOAD_ISSUE;
            LOAD_ISSUE:   w_next_state = LOAD_CAPTURE;
            LOAD_CAPTURE: w_next_state = RESP;
            RESP:         w_next_state = IDLE;
            default:      w_next_state = IDLE;
        endcase
    end

    // Packets are registered: they reflect the state being entered next cycle.
    always_comb begin
        w_pkts_next = '0;
        if (w_next_state == STORE) begin
            if (r_state == STORE) begin
                w_pkts_next = r_pkts;
            end else begin
                for (int i = 0; i < LANES; i++) begin
                    w_pkts_next[i].en         = w_req.mask[i];
                    w_pkts_next[i].addr       = w_req.addr[i];
                    w_pkts_next[i].data       = w_req.data[i];
                    w_pkts_next[i].forcewrite = w_req.forcewrite;
                end
            end
        end else if (w_next_state == LOAD_ISSUE) begin
            for (int i = 0; i < LANES; i++) begin
                w_pkts_next[i].addr = w_load_addrs[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_pkts       <= '0;
            r_base       <= '0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
        end else begin
            r_state      <= w_next_state;
            r_pkts       <= w_pkts_next;
            r_resp_valid <= (r_state == LOAD_CAPTURE);
            if (w_accept) begin
                r_base <= w_req.base_addr;
            end
            if (r_state == LOAD_CAPTURE) begin
                r_resp_data <= mmu_read_data;
            end
        end
    end

    // A retiring store restarts the drain window; otherwise count down on unstalled cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_drain_cnt <= '0;
        end else if (r_state == STORE && !mmu_stall) begin
            r_drain_cnt <= CNT_W'(DRAIN_CYCLES);
        end else if (!mmu_stall && r_drain_cnt != '0) begin
            r_drain_cnt <= r_drain_cnt - CNT_W'(1);
        end
    end

    assign mmu_write_reqs  = r_pkts;
    assign resp_valid      = r_resp_valid;
    assign resp_data       = r_resp_data;
    assign busy            = (r_state != IDLE) || (r_drain_cnt != '0);
    assign o_dbg_state     = r_state;
    assign o_dbg_drain_cnt = r_drain_cnt;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus randomized traffic against an MMU memory model.
module tb_load_store_unit;
    import memory_pkg::*;

    localparam int DRAIN = 4;

    logic                         clk;
    logic                         rst_n;
    logic                         req_valid;
    logic                         req_ready;
    logic                         req_is_store;
    logic                         req_forcewrite;
    logic [LANES-1:0]             req_mask;
    logic [ADDR_W-1:0]            req_base_addr;
    logic [LANES-1:0][ADDR_W-1:0] req_addr;
    logic [LANES-1:0][DATA_W-1:0] req_data;
    write_req_pkt [LANES-1:0]     mmu_write_reqs;
    logic                         mmu_stall;
    logic [LANES-1:0][DATA_W-1:0] mmu_read_data;
    logic                         resp_valid;
    logic [LANES-1:0][DATA_W-1:0] resp_data;
    logic                         busy;
    logic [2:0]                   o_dbg_state;
    logic [2:0]                   o_dbg_drain_cnt;

    load_store_unit #(.DRAIN_CYCLES(DRAIN)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_is_store(req_is_store), .req_forcewrite(req_forcewrite),
        .req_mask(req_mask), .req_base_addr(req_base_addr),
        .req_addr(req_addr), .req_data(req_data),
        .mmu_write_reqs(mmu_write_reqs), .mmu_stall(mmu_stall),
        .mmu_read_data(mmu_read_data),
        .resp_valid(resp_valid), .resp_data(resp_data), .busy(busy),
        .o_dbg_state(o_dbg_state), .o_dbg_drain_cnt(o_dbg_drain_cnt)
    );

    // ---------------- clock / reset / counters ----------------
    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    logic [DATA_W-1:0] salt = '0;
    bit stall_ovr = 1'b1;
    int stall_pct = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #2;
        if (!stall_ovr) mmu_stall = ($urandom_range(99) < stall_pct);
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- MMU memory model: data one cycle after the address ----------------
    function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        return a[DATA_W-1:0] ^ salt;
    endfunction

    logic [LANES-1:0][ADDR_W-1:0] mmu_addr_d = '0;
    always @(negedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            mmu_read_data[i] = mem_word(mmu_addr_d[i]);
            mmu_addr_d[i]    = mmu_write_reqs[i].addr;
        end
    end

    function automatic logic [LANES-1:0] get_en(input write_req_pkt [LANES-1:0] w);
        for (int i = 0; i < LANES; i++) get_en[i] = w[i].en;
    endfunction

    function automatic logic [ADDR_W-1:0] wrap_add(input logic [ADDR_W-1:0] b, input int i);
        return ADDR_W'((int'(b) + i) % (1 << ADDR_W));
    endfunction

    // ---------------- scoreboard / monitor ----------------
    write_req_pkt [LANES-1:0]     st_q[$];
    int                           st_cyc_q[$];
    logic [LANES*DATA_W-1:0]      exp_q[$];
    bit                           st_seen = 0;
    bit                           ld_pending = 0;
    bit                           ld_sched = 0;
    int                           ld_acc = 0;
    int                           ld_issue_exp = 0;
    int                           ld_resp_exp = 0;
    logic [ADDR_W-1:0]            ld_base = '0;
    int                           ns_cnt = 1000;
    int                           last_retire_cyc = 0;
    int                           last_issue_cyc = 0;

    always @(negedge clk) begin
        bit retired;
        write_req_pkt [LANES-1:0] ew;
        logic [LANES-1:0][DATA_W-1:0] er;
        retired = 1'b0;
        if (!rst_n) begin
            st_q.delete(); st_cyc_q.delete(); exp_q.delete();
            st_seen = 0; ld_pending = 0; ld_sched = 0; ns_cnt = 1000;
        end else begin
            if (get_en(mmu_write_reqs) != '0) begin
                if (st_q.size() == 0) begin
                    chk("store_pkt_unexpected", 256'(mmu_write_reqs), 256'(0));
                end else begin
                    if (!st_seen) begin
                        chk("store_issue_cycle", 256'(cyc), 256'(st_cyc_q[0]));
                        st_seen = 1;
                    end
                    chk("store_pkt", 256'(mmu_write_reqs), 256'(st_q[0]));
                    if (!mmu_stall) begin
                        void'(st_q.pop_front()); void'(st_cyc_q.pop_front());
                        st_seen = 0; retired = 1'b1; ns_cnt = 0; last_retire_cyc = cyc;
                    end
                end
            end else if (mmu_write_reqs != '0) begin
                if (!ld_sched) begin
                    chk("load_addr_unexpected", 256'(mmu_write_reqs), 256'(0));
                end else begin
                    ew = '0;
                    for (int i = 0; i < LANES; i++) ew[i].addr = wrap_add(ld_base, i);
                    chk("load_issue_cycle", 256'(cyc), 256'(ld_issue_exp));
                    chk("load_addrs", 256'(mmu_write_reqs), 256'(ew));
                    ld_resp_exp = cyc + 2; last_issue_cyc = cyc;
                    ld_pending = 0; ld_sched = 0;
                end
            end
            if (resp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("resp_unexpected", 256'(resp_valid), 256'(0));
                end else begin
                    chk("resp_cycle", 256'(cyc), 256'(ld_resp_exp));
                    chk("resp_data", 256'(resp_data), 256'(exp_q.pop_front()));
                end
            end
            if (req_valid && req_ready) begin
                if (req_is_store) begin
                    if (req_mask != '0) begin
                        for (int i = 0; i < LANES; i++) begin
                            ew[i].en = req_mask[i]; ew[i].addr = req_addr[i];
                            ew[i].data = req_data[i]; ew[i].forcewrite = req_forcewrite;
                        end
                        st_q.push_back(ew); st_cyc_q.push_back(cyc + 1);
                    end
                end else begin
                    ld_pending = 1; ld_sched = 0; ld_acc = cyc; ld_base = req_base_addr;
                    for (int i = 0; i < LANES; i++) er[i] = mem_word(wrap_add(req_base_addr, i));
                    exp_q.push_back(er);
                end
            end
            // A load may go once DRAIN unstalled cycles have passed since the last retirement.
            if (ld_pending && !ld_sched && ns_cnt >= DRAIN && !mmu_stall) begin
                ld_sched = 1; ld_issue_exp = cyc + 1;
            end
            if (!mmu_stall && !retired && ns_cnt < 1000) ns_cnt++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input bit st, input bit fw, input logic [LANES-1:0] m,
                        input logic [ADDR_W-1:0] b,
                        input logic [LANES-1:0][ADDR_W-1:0] a,
                        input logic [LANES-1:0][DATA_W-1:0] d);
        bit got;
        got = 0;
        req_is_store = st; req_forcewrite = fw; req_mask = m;
        req_base_addr = b; req_addr = a; req_data = d; req_valid = 1'b1;
        for (int t = 0; t < 300 && !got; t++) begin
            @(negedge clk);
            if (req_ready) got = 1;
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        if (!got) chk("accept_timeout", 256'(got), 256'(1));
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 0;
        for (int t = 0; t < 400 && !idle; t++) begin
            @(negedge clk);
            if (!busy) idle = 1;
        end
        if (!idle) chk("idle_timeout", 256'(idle), 256'(1));
        @(posedge clk); #1;
    endtask

    function automatic logic [LANES-1:0][ADDR_W-1:0] rnd_addrs();
        for (int i = 0; i < LANES; i++) rnd_addrs[i] = ADDR_W'($urandom);
    endfunction

    function automatic logic [LANES-1:0][DATA_W-1:0] rnd_data();
        for (int i = 0; i < LANES; i++) rnd_data[i] = DATA_W'($urandom);
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        logic [LANES-1:0][ADDR_W-1:0] a;
        logic [LANES-1:0][DATA_W-1:0] d;
        logic [LANES-1:0][DATA_W-1:0] wrap_exp;
        logic [LANES-1:0] m;
        logic [ADDR_W-1:0] b;

        rst_n = 1'b0; req_valid = 1'b0; req_is_store = 1'b0; req_forcewrite = 1'b0;
        req_mask = '0; req_base_addr = '0; req_addr = '0; req_data = '0; mmu_stall = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 256'(req_ready), 256'(1));
        chk("rst_busy", 256'(busy), 256'(0));
        chk("rst_resp_valid", 256'(resp_valid), 256'(0));
        chk("rst_resp_data", 256'(resp_data), 256'(0));
        chk("rst_pkts", 256'(mmu_write_reqs), 256'(0));
        chk("rst_state", 256'(o_dbg_state), 256'(IDLE));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Full-mask store, no stall.
        for (int i = 0; i < LANES; i++) begin a[i] = ADDR_W'(16 + i); d[i] = DATA_W'(i + 1); end
        send(1'b1, 1'b0, 8'hFF, '0, a, d);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            chk("store_busy", 256'(busy), 256'(k <= 5));
            if (k == 1) chk("store_en_c1", 256'(get_en(mmu_write_reqs)), 256'(8'hFF));
            if (k == 2) chk("store_en_c2", 256'(get_en(mmu_write_reqs)), 256'(0));
            if (k == 1) chk("store_ready_c1", 256'(req_ready), 256'(0));
            if (k == 2) chk("store_ready_c2", 256'(req_ready), 256'(1));
            @(posedge clk); #1;
        end

        // Stalled store: stall cycles 1-3, retire at 4.
        send(1'b1, 1'b1, 8'h05, '0, rnd_addrs(), rnd_data());
        mmu_stall = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk("stall_store_en", 256'(get_en(mmu_write_reqs)), 256'(k <= 4 ? 8'h05 : 8'h00));
            if (k == 5) chk("stall_store_drain", 256'(o_dbg_drain_cnt), 256'(DRAIN));
            @(posedge clk); #1;
            mmu_stall = (k + 1 <= 3);
        end
        wait_idle();

        // Load right behind a store: drain gates the issue.
        send(1'b1, 1'b0, 8'hA5, '0, rnd_addrs(), rnd_data());
        send(1'b0, 1'b0, '0, ADDR_W'($urandom), rnd_addrs(), rnd_data());
        wait_idle();
        chk("load_after_store_gap", 256'(last_issue_cyc - last_retire_cyc), 256'(DRAIN + 2));

        // Wrap-around load with drain already zero.
        send(1'b0, 1'b0, '0, 18'h3FFFE, rnd_addrs(), rnd_data());
        wrap_exp = {9'h5, 9'h4, 9'h3, 9'h2, 9'h1, 9'h0, 9'h1FF, 9'h1FE};
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (k == 1) begin
                chk("wrap_lane0", 256'(mmu_write_reqs[0].addr), 256'(18'h3FFFE));
                chk("wrap_lane2", 256'(mmu_write_reqs[2].addr), 256'(0));
                chk("wrap_lane7", 256'(mmu_write_reqs[7].addr), 256'(5));
            end
            chk("wrap_resp_valid", 256'(resp_valid), 256'(k == 3));
            if (k == 3) chk("wrap_resp_data", 256'(resp_data), 256'(wrap_exp));
            @(posedge clk); #1;
        end
        wait_idle();

        // Zero-mask store, then a load that issues without any drain wait.
        send(1'b1, 1'b0, '0, '0, rnd_addrs(), rnd_data());
        @(negedge clk);
        chk("zmask_en", 256'(get_en(mmu_write_reqs)), 256'(0));
        chk("zmask_drain", 256'(o_dbg_drain_cnt), 256'(0));
        chk("zmask_ready", 256'(req_ready), 256'(1));
        @(posedge clk); #1;
        send(1'b0, 1'b0, '0, ADDR_W'($urandom), rnd_addrs(), rnd_data());
        wait_idle();
        chk("zmask_load_gap", 256'(last_issue_cyc - ld_acc), 256'(1));

        // Reset in the middle of a stalled store.
        send(1'b1, 1'b0, 8'h3C, '0, rnd_addrs(), rnd_data());
        mmu_stall = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstmid_en", 256'(get_en(mmu_write_reqs)), 256'(0));
        chk("rstmid_ready", 256'(req_ready), 256'(1));
        chk("rstmid_busy", 256'(busy), 256'(0));
        chk("rstmid_resp_valid", 256'(resp_valid), 256'(0));
        @(posedge clk); #1;
        mmu_stall = 1'b0;

        // Randomized traffic with random MMU stalls.
        salt = DATA_W'($urandom);
        stall_pct = 30;
        stall_ovr = 1'b0;
        for (int n = 0; n < 150; n++) begin
            m = ($urandom_range(7) == 0) ? '0 : LANES'($urandom_range(255));
            b = ($urandom_range(3) == 0) ? ADDR_W'(18'h3FFF8 + ADDR_W'($urandom_range(7)))
                                         : ADDR_W'($urandom);
            send(1'($urandom_range(1)), 1'($urandom_range(1)), m, b, rnd_addrs(), rnd_data());
            repeat ($urandom_range(2)) begin @(posedge clk); #1; end
        end
        wait_idle();
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("queues_drained", 256'(st_q.size() + exp_q.size() + int'(ld_pending)), 256'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Per-warp load/store sequencer that sits directly upstream of the banked MMU.
- Accepts one 8-lane memory instruction at a time over a valid/ready handshake.
- Stores: drives lane-masked write packets and holds them while the MMU stalls.
- Loads: waits for in-flight MMU queue writes to drain, issues one aligned consecutive read, and returns the 8 read words one cycle after the MMU produces them.

Parameters:
- LANES, 8, number of lanes; fixed to MMU width.
- ADDR_W, 18, address width, matching write_req_pkt.addr.
- DATA_W, 9, data width, matching write_req_pkt.data.
- DRAIN_CYCLES, 4, non-stalled cycles after a store completes before a load may issue; must be at least the MMU queue depth in stages.

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, synchronous active-low reset.
- req_valid, input, 1, instruction offered.
- req_ready, output, 1, unit can accept.
- req_is_store, input, 1, 1 = store, 0 = load.
- req_forcewrite, input, 1, copied into the forcewrite field of every store packet.
- req_mask, input, LANES, per-lane store enable; ignored for loads.
- req_base_addr, input, ADDR_W, load base; lane i reads base+i.
- req_addr, input, LANES x ADDR_W, per-lane store addresses.
- req_data, input, LANES x DATA_W, per-lane store data.
- mmu_write_reqs, output, LANES x write_req_pkt, to MMU write_reqs.
- mmu_stall, input, 1, MMU stall.
- mmu_read_data, input, LANES x DATA_W, MMU output_read_data.
- resp_valid, output, 1, load data valid (1-cycle pulse).
- resp_data, output, LANES x DATA_W, load result; lane i = mem[base+i].
- busy, output, 1, state != IDLE or drain_cnt != 0.

Behaviour:
- Clock and reset: one clock, clk; rst_n is synchronous and active-low.
- Reset values: state=IDLE, drain_cnt=0, all packet fields 0, resp_valid=0, resp_data=0, req_ready=1.
- All outputs are registered, except req_ready and busy, which decode state only.
- Reset mid-operation abandons the instruction. Packets already inside the MMU queues are unaffected.
- Handshake: transfer occurs when req_valid && req_ready. req_ready = (state==IDLE) and is independent of req_valid.
- Store, all-zero mask: accepted, no packet issued, IDLE the next cycle, drain_cnt unchanged.
- Store, nonzero mask: go to STORE. Packets appear on the cycle after accept:
  - en[i] = mask[i]; addr, data, forcewrite taken from the request.
  - Packets are held bit-stable every cycle mmu_stall=1.
  - The first STORE cycle with mmu_stall=0 retires the store: next cycle all en=0, drain_cnt=DRAIN_CYCLES, state=IDLE.
  - Contract with the MMU: stall=1 means not consumed; stall=0 means consumed.
- Load: accepted into LOAD_WAIT.
  - Stay while drain_cnt != 0 or mmu_stall=1. Otherwise go to LOAD_ISSUE.
  - LOAD_ISSUE (1 cycle): lane i addr = req_base_addr + i (mod 2^ADDR_W); en=0, data=0, forcewrite=0.
  - LOAD_CAPTURE (1 cycle): packets return to all-zero; resp_data <= mmu_read_data.
  - RESP (1 cycle): resp_valid=1, then IDLE.
- Load latency with drain_cnt=0 and no stall: accept at N, addresses at N+1, resp_valid at N+3, req_ready at N+4.
- drain_cnt: decrements by 1 on every cycle with mmu_stall=0 and drain_cnt>0; holds while stalled. A store retirement reloads it, overriding the decrement.
- Store-to-store: back-to-back stores are allowed with no drain wait; each issues on the cycle after its accept.
- Base wrap-around: base+i wraps modulo 2^ADDR_W, so lane 0 may sit at any offset within a bank group.
- Never in the same cycle: en=1 with load addresses, or load addresses during a stall.
- resp_data holds its value until the next LOAD_CAPTURE.

Decomposition:
- memory_pkg (existing) gains:
  - LANES, ADDR_W, DATA_W constants;
  - lsu_state_t enum: IDLE, STORE, LOAD_WAIT, LOAD_ISSUE, LOAD_CAPTURE, RESP;
  - lsu_req_t struct bundling the request fields.
- write_req_pkt is reused unchanged.
- No sub-module. The drain counter and FSM are both small and stay inline.

Test Plan:
- Store, no stall: mask=8'hFF, addr[i]=16+i, data[i]=i+1, accept at cycle 0 → all en=1 at cycle 1 only; busy=1 for cycles 1..5; req_ready=1 at cycle 2.
- Stalled store: mask=8'h05, mmu_stall=1 for cycles 1-3 → lanes 0 and 2 (en=1) held bit-stable cycles 1-4; en=0 at cycle 5; drain_cnt=4 at cycle 5.
- Load after store: store retires at T, load accepted at T+1 with no stall → addresses presented no earlier than T+4 (drain) and exactly one cycle after drain_cnt hits 0.
- Load with wrap-around, drain=0: base=18'h3FFFE, model returns mem[a]=a[8:0] → lane 0..7 addrs 3FFFE, 3FFFF, 0..5; resp_valid pulse 3 cycles after accept; resp_data = {1FE, 1FF, 0, 1, 2, 3, 4, 5}.
- Zero-mask store then load: mask=0 → no en ever asserted, drain_cnt stays 0, following load issues addresses 1 cycle after its accept.
- Reset mid-store: rst_n=0 during STORE with mmu_stall=1 → next cycle all en=0, req_ready=1, busy=0, resp_valid=0.
